// File: rtl/tx_timer_pkg.sv
// ---------------------------------------------------------------------------
// tx_timer_pkg
// Shared definitions for the I2C-style transmit burst timer:
//   - tx_state_e   : sequencer state encoding
//   - DEF_*        : default values for DATA_BITS, MAX_BYTES, TIMEOUT_CYCLES
//   - cnt_width()  : width of a counter that must hold 0..max_val
//   - clamp_len()  : maps a requested burst length onto 1..max_len
// No ports (package).
// ---------------------------------------------------------------------------
package tx_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ACK_FALL,
        ACK_RISE,
        ACK_END
    } tx_state_e;

    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_MAX_BYTES      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Bits needed to represent every value from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // A zero length still sends one byte; oversize requests saturate.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Up-counter with synchronous clear and programmable rollover. When the
// count equals rollover_val and count_enable is high, the next value is 1.
// Ports:
//   clk           in   system clock
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous clear to 0 (wins over count_enable)
//   count_enable  in   advance the count by one
//   rollover_val  in   highest value before wrapping back to 1
//   count_out     out  current count (registered)
// ---------------------------------------------------------------------------
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (count_enable) begin
            w_count_next = (r_count == rollover_val) ? NUM_CNT_BITS'(1)
                                                     : r_count + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/tx_burst_timer.sv
// ---------------------------------------------------------------------------
// tx_burst_timer
// Bit/byte sequencer for the transmit path. Counts SCL edge strobes, emits
// single-cycle phase pulses (data shift, byte end, ACK release/sample/end),
// and repeats bytes for a burst of programmable length with NACK and stop
// abort. Optional watchdog abort is compiled in with TX_TIMER_TIMEOUT_EN.
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   rising_edge, falling_edge  one-cycle SCL edge strobes
//   start, stop                begin burst (idle only) / abort burst
//   burst_len [BW]             bytes in burst, sampled on start
//   sda_in                     SDA sampled on the ACK rising edge
//   shift_strobe, byte_received, ack_ready, check_ack, ack_done,
//   load_byte, burst_done, timeout   registered one-cycle pulses
//   nack                       sticky NACK flag, cleared by accepted start
//   busy                       high whenever not IDLE
//   byte_index [BW]            0-based index of the current byte
// ---------------------------------------------------------------------------
module tx_burst_timer
    import tx_timer_pkg::*;
#(
    parameter  int DATA_BITS      = DEF_DATA_BITS,
    parameter  int MAX_BYTES      = DEF_MAX_BYTES,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int BW             = cnt_width(MAX_BYTES)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          rising_edge,
    input  logic          falling_edge,
    input  logic          start,
    input  logic          stop,
    input  logic [BW-1:0] burst_len,
    input  logic          sda_in,
    output logic          shift_strobe,
    output logic          byte_received,
    output logic          ack_ready,
    output logic          check_ack,
    output logic          ack_done,
    output logic          load_byte,
    output logic          burst_done,
    output logic          nack,
    output logic          timeout,
    output logic          busy,
    output logic [BW-1:0] byte_index
);

    localparam int BCW = cnt_width(DATA_BITS);

    tx_state_e      r_state;
    logic [BW-1:0]  r_len;
    logic [BW-1:0]  r_byte_cnt;
    logic           r_nack;
    logic           r_busy;
    logic           r_shift_strobe;
    logic           r_byte_received;
    logic           r_ack_ready;
    logic           r_check_ack;
    logic           r_ack_done;
    logic           r_load_byte;
    logic           r_burst_done;

    logic [BCW-1:0] w_bit_cnt;
    logic           w_start_acc;
    logic           w_stop_acc;
    logic           w_timeout_hit;
    logic           w_last_byte;
    logic           w_load;
    logic           w_bit_clear;
    logic           w_bit_en;

    assign w_start_acc = start && (r_state == IDLE);
    assign w_stop_acc  = stop && (r_state != IDLE);
    assign w_last_byte = (r_byte_cnt == r_len - BW'(1));

    // Advancing to the next byte of the burst at the end of the ACK clock.
    assign w_load = (r_state == ACK_END) && falling_edge && !w_stop_acc &&
                    !w_timeout_hit && !(r_nack || w_last_byte);

    assign w_bit_clear = w_start_acc || w_stop_acc || w_timeout_hit || w_load;
    assign w_bit_en    = (r_state == DATA) && rising_edge && !w_stop_acc;

    flex_counter #(
        .NUM_CNT_BITS (BCW)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_bit_clear),
        .count_enable (w_bit_en),
        .rollover_val (BCW'(DATA_BITS)),
        .count_out    (w_bit_cnt)
    );

`ifdef TX_TIMER_TIMEOUT_EN
    localparam int WDW = cnt_width(TIMEOUT_CYCLES);

    logic [WDW-1:0] r_wd;
    logic           r_timeout;

    // Fires on the TIMEOUT_CYCLES-th consecutive busy cycle without an edge.
    assign w_timeout_hit = (r_state != IDLE) && !stop && !rising_edge &&
                           !falling_edge && (r_wd == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if ((r_state == IDLE) || rising_edge || falling_edge || w_timeout_hit) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + WDW'(1);
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= IDLE;
            r_len           <= '0;
            r_byte_cnt      <= '0;
            r_nack          <= 1'b0;
            r_busy          <= 1'b0;
            r_shift_strobe  <= 1'b0;
            r_byte_received <= 1'b0;
            r_ack_ready     <= 1'b0;
            r_check_ack     <= 1'b0;
            r_ack_done      <= 1'b0;
            r_load_byte     <= 1'b0;
            r_burst_done    <= 1'b0;
        end else begin
            r_shift_strobe  <= 1'b0;
            r_byte_received <= 1'b0;
            r_ack_ready     <= 1'b0;
            r_check_ack     <= 1'b0;
            r_ack_done      <= 1'b0;
            r_load_byte     <= 1'b0;
            r_burst_done    <= 1'b0;

            // Aborts take precedence over any edge in the same cycle and
            // leave nack untouched so the controller can still inspect it.
            if (w_stop_acc || w_timeout_hit) begin
                r_state    <= IDLE;
                r_byte_cnt <= '0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_len      <= BW'(clamp_len(int'(burst_len), MAX_BYTES));
                            r_byte_cnt <= '0;
                            r_nack     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= DATA;
                        end
                    end
                    DATA: begin
                        // bit_cnt of 0 means no bit has been clocked yet, so
                        // a leading falling edge has nothing to shift.
                        if (falling_edge && (w_bit_cnt != '0) &&
                            (w_bit_cnt <= BCW'(DATA_BITS - 1))) begin
                            r_shift_strobe <= 1'b1;
                        end
                        if (rising_edge && (w_bit_cnt == BCW'(DATA_BITS - 1))) begin
                            r_byte_received <= 1'b1;
                            r_state         <= ACK_FALL;
                        end
                    end
                    ACK_FALL: begin
                        if (falling_edge) begin
                            r_ack_ready <= 1'b1;
                            r_state     <= ACK_RISE;
                        end
                    end
                    ACK_RISE: begin
                        if (rising_edge) begin
                            r_check_ack <= 1'b1;
                            if (sda_in) begin
                                r_nack <= 1'b1;
                            end
                            r_state <= ACK_END;
                        end
                    end
                    ACK_END: begin
                        if (falling_edge) begin
                            r_ack_done <= 1'b1;
                            if (r_nack || w_last_byte) begin
                                r_burst_done <= 1'b1;
                                r_busy       <= 1'b0;
                                r_state      <= IDLE;
                            end else begin
                                r_byte_cnt  <= r_byte_cnt + BW'(1);
                                r_load_byte <= 1'b1;
                                r_state     <= DATA;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_strobe  = r_shift_strobe;
    assign byte_received = r_byte_received;
    assign ack_ready     = r_ack_ready;
    assign check_ack     = r_check_ack;
    assign ack_done      = r_ack_done;
    assign load_byte     = r_load_byte;
    assign burst_done    = r_burst_done;
    assign nack          = r_nack;
    assign busy          = r_busy;
    assign byte_index    = r_byte_cnt;

endmodule

// File: tb/tb_tx_burst_timer.sv
// ---------------------------------------------------------------------------
// tb_tx_burst_timer
// Self-checking bench for tx_burst_timer. A byte is modelled as a script of
// SCL clocks: clock c (1..DATA_BITS+1) is a rising then a falling edge; the
// model tracks the position in that script and derives each expected pulse
// from the clock number. Honours TX_TIMER_TIMEOUT_EN for the watchdog.
// ---------------------------------------------------------------------------
module tb_tx_burst_timer;

    localparam int DATA_BITS      = 8;
    localparam int MAX_BYTES      = 16;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int BW             = $clog2(MAX_BYTES + 1);
    localparam int OW             = 10 + BW;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          rising_edge = 1'b0;
    logic          falling_edge = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          sda_in = 1'b0;
    logic          shift_strobe, byte_received, ack_ready, check_ack, ack_done;
    logic          load_byte, burst_done, nack, timeout, busy;
    logic [BW-1:0] byte_index;

    always #5 clk = ~clk;

    tx_burst_timer #(
        .DATA_BITS      (DATA_BITS),
        .MAX_BYTES      (MAX_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rising_edge   (rising_edge),
        .falling_edge  (falling_edge),
        .start         (start),
        .stop          (stop),
        .burst_len     (burst_len),
        .sda_in        (sda_in),
        .shift_strobe  (shift_strobe),
        .byte_received (byte_received),
        .ack_ready     (ack_ready),
        .check_ack     (check_ack),
        .ack_done      (ack_done),
        .load_byte     (load_byte),
        .burst_done    (burst_done),
        .nack          (nack),
        .timeout       (timeout),
        .busy          (busy),
        .byte_index    (byte_index)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_busy = 0;
    bit m_nack = 0;
    int m_pos  = 0;   // index into the 2*(DATA_BITS+1) edge script of a byte
    int m_byte = 0;
    int m_len  = 0;
    int m_wd   = 0;

    // Pulse tallies taken from the DUT for per-scenario totals
    int cnt_shift, cnt_br, cnt_load, cnt_bd, cnt_to;

    task automatic clear_counts();
        cnt_shift = 0; cnt_br = 0; cnt_load = 0; cnt_bd = 0; cnt_to = 0;
    endtask

    function automatic logic [OW-1:0] observed();
        return {shift_strobe, byte_received, ack_ready, check_ack, ack_done,
                load_byte, burst_done, nack, timeout, busy, byte_index};
    endfunction

    task automatic check_vec(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input bit r, input bit f, input bit st, input bit sp,
                        input int len, input bit sda, input string tag);
        bit e_sh, e_br, e_ar, e_ca, e_ad, e_ld, e_bd, e_to;
        int clock_no;
        e_sh = 0; e_br = 0; e_ar = 0; e_ca = 0; e_ad = 0; e_ld = 0; e_bd = 0; e_to = 0;
        rising_edge  = r;
        falling_edge = f;
        start        = st;
        stop         = sp;
        burst_len    = BW'(len);
        sda_in       = sda;

        if (!m_busy) begin
            if (st) begin
                m_busy = 1;
                m_len  = (len == 0) ? 1 : ((len > MAX_BYTES) ? MAX_BYTES : len);
                m_byte = 0;
                m_pos  = 0;
                m_nack = 0;
                m_wd   = 0;
            end
        end else if (sp) begin
            m_busy = 0;
            m_byte = 0;
            m_pos  = 0;
        end else if (!r && !f) begin
`ifdef TX_TIMER_TIMEOUT_EN
            if (m_wd == TIMEOUT_CYCLES - 1) begin
                e_to   = 1;
                m_busy = 0;
                m_byte = 0;
                m_pos  = 0;
            end
`endif
            m_wd++;
        end else begin
            m_wd     = 0;
            clock_no = m_pos / 2 + 1;
            if ((m_pos % 2 == 0) && r) begin
                if (clock_no == DATA_BITS) e_br = 1;
                if (clock_no == DATA_BITS + 1) begin
                    e_ca = 1;
                    if (sda) m_nack = 1;
                end
                m_pos++;
            end else if ((m_pos % 2 == 1) && f) begin
                if (clock_no < DATA_BITS) begin
                    e_sh = 1;
                    m_pos++;
                end else if (clock_no == DATA_BITS) begin
                    e_ar = 1;
                    m_pos++;
                end else begin
                    e_ad  = 1;
                    m_pos = 0;
                    if (m_nack || (m_byte == m_len - 1)) begin
                        e_bd   = 1;
                        m_busy = 0;
                    end else begin
                        e_ld = 1;
                        m_byte++;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        check_vec(tag, observed(),
                  {e_sh, e_br, e_ar, e_ca, e_ad, e_ld, e_bd, m_nack, e_to, m_busy, BW'(m_byte)});
        $display("%0t %s r=%0b f=%0b st=%0b sp=%0b busy=%0b idx=%0d nack=%0b", $time, tag,
                 r, f, st, sp, busy, byte_index, nack);
        cnt_shift += int'(shift_strobe);
        cnt_br    += int'(byte_received);
        cnt_load  += int'(load_byte);
        cnt_bd    += int'(burst_done);
        cnt_to    += int'(timeout);
    endtask

    // Runs a burst edge by edge. nack_byte selects which byte is NACKed (-1
    // for none); stop_at aborts together with that edge (-1 for never).
    task automatic run_burst(input int len, input int nack_byte, input bit noise,
                             input int stop_at, input string tag);
        int  edges, guard, gap;
        bit  is_r, both, sda, sp, in_quiet;
        edges = 0;
        guard = 0;
        step(0, 0, 1, 0, len, 0, {tag, "_start"});
        while (m_busy && guard < 4000) begin
            guard++;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                // A start while busy must be ignored.
                step(0, 0, ($urandom_range(0, 3) == 0), 0, $urandom_range(0, 31),
                     1'($urandom), {tag, "_gap"});
            end
            // Edges of the wrong type are harmless only where bit_cnt is 0 or
            // during the ACK clock.
            in_quiet = (m_pos == 0) || (m_pos >= 2 * DATA_BITS - 1);
            is_r     = (m_pos % 2 == 0);
            if (noise && in_quiet && ($urandom_range(0, 2) == 0)) begin
                step(!is_r, is_r, 0, 0, 0, 0, {tag, "_noise"});
            end
            both = noise && in_quiet && ($urandom_range(0, 1) == 1);
            sda  = (m_pos == 2 * DATA_BITS) ? (m_byte == nack_byte) : 1'($urandom);
            sp   = (edges == stop_at);
            step(is_r || both, !is_r || both, 0, sp, 0, sda, {tag, "_edge"});
            edges++;
            if (sp) break;
        end
        n_cmp++;
        assert (guard < 4000) else begin
            n_bad++;
            $error("FAIL %s_bound: observed=%0d expected=<4000 iterations", tag, guard);
        end
    endtask

    initial begin
        // Reset state
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", observed(), '0);
        n_rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, "post_reset");

        // Single byte with ACK
        clear_counts();
        run_burst(1, -1, 0, -1, "single");
        check_int("single_shift_cnt", cnt_shift, DATA_BITS - 1);
        check_int("single_byte_rx_cnt", cnt_br, 1);
        check_int("single_burst_done_cnt", cnt_bd, 1);
        check_int("single_load_cnt", cnt_load, 0);

        // Burst of 3
        clear_counts();
        run_burst(3, -1, 0, -1, "burst3");
        check_int("burst3_load_cnt", cnt_load, 2);
        check_int("burst3_byte_rx_cnt", cnt_br, 3);
        check_int("burst3_last_index", int'(byte_index), 2);

        // NACK on byte 1 of a 4-byte burst; nack holds until next start
        clear_counts();
        run_burst(4, 1, 0, -1, "nack");
        check_int("nack_load_cnt", cnt_load, 1);
        check_int("nack_burst_done_cnt", cnt_bd, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, "nack_hold");
        check_int("nack_sticky", int'(nack), 1);
        run_burst(1, -1, 0, -1, "nack_clear");

        // Stop together with the 5th rising edge (edge index 8)
        clear_counts();
        run_burst(2, -1, 0, 8, "stop");
        step(0, 0, 0, 0, 0, 0, "stop_idle");
        check_int("stop_byte_rx_cnt", cnt_br, 0);
        check_int("stop_burst_done_cnt", cnt_bd, 0);
        clear_counts();
        run_burst(1, -1, 0, -1, "after_stop");
        check_int("after_stop_shift_cnt", cnt_shift, DATA_BITS - 1);

        // Length 0 behaves as 1; oversize saturates
        clear_counts();
        run_burst(0, -1, 0, -1, "len0");
        check_int("len0_load_cnt", cnt_load, 0);
        clear_counts();
        run_burst(31, -1, 0, -1, "len_sat");
        check_int("len_sat_load_cnt", cnt_load, MAX_BYTES - 1);

        // Ignored / simultaneous edges during ACK phases
        clear_counts();
        run_burst(2, -1, 1, -1, "noise");
        check_int("noise_byte_rx_cnt", cnt_br, 2);

        // Randomised bursts
        for (int i = 0; i < 8; i++) begin
            int len, nb, sa;
            len = $urandom_range(0, 5);
            nb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            sa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
            run_burst(len, nb, 1'($urandom), sa, "rand");
        end

        // Watchdog: no edges after start
        clear_counts();
        step(0, 0, 1, 0, 2, 0, "wd_start");
        repeat (TIMEOUT_CYCLES + 2) step(0, 0, 0, 0, 0, 0, "wd_idle");
`ifdef TX_TIMER_TIMEOUT_EN
        check_int("wd_timeout_cnt", cnt_to, 1);
        check_int("wd_busy", int'(busy), 0);
`else
        check_int("wd_timeout_cnt", cnt_to, 0);
        check_int("wd_busy", int'(busy), 1);
`endif
        check_int("wd_burst_done_cnt", cnt_bd, 0);
        if (m_busy) step(0, 0, 0, 1, 0, 0, "wd_stop");

        // Asynchronous reset mid-burst
        step(0, 0, 1, 0, 3, 0, "areset_start");
        for (int k = 0; k < 6; k++) step(k % 2 == 0, k % 2 == 1, 0, 0, 0, 0, "areset_edge");
        n_rst = 1'b0;
        #1;
        check_vec("areset_async", observed(), '0);
        m_busy = 0; m_nack = 0; m_pos = 0; m_byte = 0; m_wd = 0;
        #1;
        n_rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, "areset_idle");
        run_burst(1, -1, 0, -1, "areset_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
